// File: rtl/inst_fetch_queue.sv
// Fetch unit plus decoupling FIFO: reads the instruction ROM at fetch_pc and queues {pc, inst}.
// Define INSTQ_BYPASS_EN to present the fetch word straight to dispatch when the queue is empty.
module inst_fetch_queue #(
    parameter int unsigned             DEPTH    = 8,
    parameter int unsigned             IM_DEPTH = 1024,
    parameter logic [31:0]             RST_PC   = 32'd0,
    parameter logic [IM_DEPTH*32-1:0]  IM_INIT  = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fetch_en,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    input  logic                      out_ready,
    output logic                      VALID_Inst,
    output logic [31:0]               pc,
    output logic [11:0]               opcode,
    output logic [4:0]                rs,
    output logic [4:0]                rt,
    output logic [4:0]                rd,
    output logic [4:0]                shamt,
    output logic [15:0]               immediate,
    output logic [25:0]               address,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned ImAw = $clog2(IM_DEPTH);

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [63:0]     mem_q [DEPTH];

    logic [31:0] im_rom [IM_DEPTH];
    logic [31:0] inst_f;
    logic [63:0] head;
    logic [31:0] head_inst;
    logic        byp, fetch_go, push, pop, q_pop;

    for (genvar i = 0; i < IM_DEPTH; i++) begin : g_rom
        assign im_rom[i] = IM_INIT[i*32 +: 32];
    end

    assign inst_f = im_rom[fetch_pc_q[ImAw-1:0]];
    assign empty  = (count_q == '0);
    assign full   = (count_q == CntW'(DEPTH));
    assign count  = count_q;

`ifdef INSTQ_BYPASS_EN
    assign byp = empty & fetch_en & ~redirect_valid;
`else
    assign byp = 1'b0;
`endif

    assign head       = byp ? {fetch_pc_q, inst_f} : mem_q[rd_ptr_q];
    assign VALID_Inst = (~empty | byp) & ~redirect_valid;
    assign pop        = VALID_Inst & out_ready;
    // A bypassed word that is accepted never touches the queue.
    assign q_pop      = pop & ~byp;
    assign fetch_go   = fetch_en & ~redirect_valid & (~full | q_pop);
    assign push       = fetch_go & ~(byp & out_ready);

    assign pc        = head[63:32];
    assign head_inst = head[31:0];
    assign opcode    = (head_inst[31:26] == 6'd0) ? {head_inst[31:26], head_inst[5:0]}
                                                  : {head_inst[31:26], 6'd0};
    assign rs        = head_inst[25:21];
    assign rt        = head_inst[20:16];
    assign rd        = head_inst[15:11];
    assign shamt     = head_inst[10:6];
    assign immediate = head_inst[15:0];
    assign address   = head_inst[25:0];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (fetch_go) fetch_pc_d = fetch_pc_q + 32'd1;
            if (push)     wr_ptr_d   = wr_ptr_q + PtrW'(1);
            if (q_pop)    rd_ptr_d   = rd_ptr_q + PtrW'(1);
            if (push && !q_pop)      count_d = count_q + CntW'(1);
            else if (!push && q_pop) count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RST_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage has no reset; entries beyond count are don't-care.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= {fetch_pc_q, inst_f};
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue; expectations follow INSTQ_BYPASS_EN when it is defined.
module tb_inst_fetch_queue;

    localparam int unsigned Depth   = 8;
    localparam int unsigned ImDepth = 1024;

    function automatic logic [31:0] word_of(int unsigned i);
        case (i)
            0:       return 32'h0022_1820;  // add  r3, r1, r2
            1:       return 32'h2000_0005;  // addi r0, r0, 5
            2:       return 32'h8C41_0010;  // lw   r1, 0x10(r2)
            3:       return 32'h0800_0123;  // j    0x123
            default: return 32'h2000_0000 | (i & 32'hFFFF);
        endcase
    endfunction

    function automatic logic [ImDepth*32-1:0] im_image();
        logic [ImDepth*32-1:0] v;
        v = '0;
        for (int i = 0; i < ImDepth; i++) v[i*32 +: 32] = word_of(i);
        return v;
    endfunction

    localparam logic [ImDepth*32-1:0] ImImage = im_image();

    logic        clk = 1'b0;
    logic        rst, fetch_en, redirect_valid, out_ready;
    logic [31:0] redirect_pc;
    logic        valid_inst, full, empty;
    logic [31:0] pc;
    logic [11:0] opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] immediate;
    logic [25:0] address;
    logic [3:0]  count;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .DEPTH    (Depth),
        .IM_DEPTH (ImDepth),
        .RST_PC   (32'd0),
        .IM_INIT  (ImImage)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_ready      (out_ready),
        .VALID_Inst     (valid_inst),
        .pc             (pc),
        .opcode         (opcode),
        .rs             (rs),
        .rt             (rt),
        .rd             (rd),
        .shamt          (shamt),
        .immediate      (immediate),
        .address        (address),
        .count          (count),
        .full           (full),
        .empty          (empty)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [11:0] exp_op [4];
    logic [31:0] exp_pc;
    int          xfers;

    initial begin
        exp_op[0] = 12'h020;
        exp_op[1] = 12'h200;
        exp_op[2] = 12'h8C0;
        exp_op[3] = 12'h080;

        rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        step();
        rst = 1'b0;
        settle();
        check_eq("rst_valid", valid_inst, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_full",  full, 0);

        // Stream from reset PC, one instruction per cycle.
        fetch_en = 1'b1; out_ready = 1'b1;
        settle();
`ifdef INSTQ_BYPASS_EN
        check_eq("byp_same_cycle_valid", valid_inst, 1);
`else
        check_eq("nobyp_first_cycle_valid", valid_inst, 0);
        step();
`endif
        for (int k = 0; k < 4; k++) begin
            check_eq("stream_valid", valid_inst, 1);
            check_eq("stream_pc", pc, k);
            check_eq("stream_opcode", opcode, exp_op[k]);
`ifdef INSTQ_BYPASS_EN
            check_eq("stream_count", count, 0);
`else
            check_eq("stream_count", count, 1);
`endif
            if (k == 0) begin
                check_eq("rtype_rs", rs, 1);
                check_eq("rtype_rt", rt, 2);
                check_eq("rtype_rd", rd, 3);
                check_eq("rtype_shamt", shamt, 0);
            end
            if (k == 2) check_eq("lw_imm", immediate, 16'h0010);
            if (k == 3) check_eq("j_addr", address, 26'h123);
            step();
        end

        // Clean restart at 0, then fill with dispatch stalled.
        redirect_valid = 1'b1; redirect_pc = 32'd0;
        settle();
        check_eq("redir0_valid", valid_inst, 0);
        step();
        redirect_valid = 1'b0; out_ready = 1'b0;
        settle();
        check_eq("redir0_count", count, 0);
        for (int k = 0; k < Depth + 2; k++) begin
            step();
            check_eq("fill_count", count, (k + 1 < Depth) ? k + 1 : Depth);
        end
        check_eq("fill_full", full, 1);
        check_eq("fill_head_pc", pc, 0);

        // Drain while refilling: count holds at DEPTH, fetch resumes at 8.
        out_ready = 1'b1;
        for (int k = 0; k < Depth; k++) begin
            settle();
            check_eq("pushpop_pc", pc, k);
            check_eq("pushpop_count", count, Depth);
            step();
        end
        check_eq("refill_head_pc", pc, 8);

        // Leave 5 entries, then redirect with a live handshake.
        fetch_en = 1'b0;
        step(); step(); step();
        check_eq("five_count", count, 5);
        check_eq("five_head_pc", pc, 11);
        fetch_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        settle();
        check_eq("redir_cycle_valid", valid_inst, 0);
        step();
        redirect_valid = 1'b0;
        settle();
        check_eq("redir_next_count", count, 0);
`ifndef INSTQ_BYPASS_EN
        check_eq("redir_next_valid", valid_inst, 0);
        step();
`endif
        check_eq("redir_deliver_valid", valid_inst, 1);
        check_eq("redir_deliver_pc", pc, 32'h40);
        check_eq("redir_deliver_imm", immediate, 16'h0040);

        // Fetch PC wraps the ROM index but keeps the full value.
        redirect_valid = 1'b1; redirect_pc = 32'd1022;
        step();
        redirect_valid = 1'b0;
`ifndef INSTQ_BYPASS_EN
        step();
`else
        settle();
`endif
        check_eq("wrap_pc0", pc, 1022);
        check_eq("wrap_imm0", immediate, 1022);
        step();
        check_eq("wrap_pc1", pc, 1023);
        check_eq("wrap_imm1", immediate, 1023);
        step();
        check_eq("wrap_pc2", pc, 1024);
        check_eq("wrap_op2", opcode, 12'h020);
        check_eq("wrap_rd2", rd, 3);

        // Varying occupancy: every transfer must be the next PC in order.
        exp_pc = 32'd1024;
        xfers  = 0;
        for (int c = 0; c < 80; c++) begin
            out_ready = (c % 3) != 0;
            fetch_en  = (c % 7) != 6 && !(c >= 50 && c < 62);
            settle();
            if (valid_inst && out_ready) begin
                check_eq("sb_pc", pc, exp_pc);
                check_eq("sb_imm", immediate, word_of(exp_pc % ImDepth) & 32'hFFFF);
                exp_pc = exp_pc + 1;
                xfers++;
            end
            step();
        end
        check_eq("sb_enough_xfers", (xfers >= 3 * Depth), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
